pong_arbiter: RTL

PONG_ARBITER -- requirements
Module: pong_arbiter

---
 rtl/pong_pkg.sv | 20 ++
 rtl/sat_counter16.sv | 36 +++
 rtl/pong_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared constants for the two-requester ping-pong arbiter: FSM encoding,
// beat-counter width, saturating-counter width and default parameters.
package pong_pkg;

    localparam int WIDTH_DEFAULT = 704;
    localparam int BURST_DEFAULT = 4;

    localparam int BEAT_W = 4;
    localparam int CNT_W  = 16;

    typedef logic [1:0]       state_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT0 = 2'd1;
    localparam logic [1:0] ST_GRANT1 = 2'd2;

    localparam cnt_t CNT_MAX = '1;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit counter that sticks at all-ones; a load port allows presetting it.
module sat_counter16
    import pong_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Load wins over increment; reset wins over both.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (inc_i && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pong_arbiter.sv
// Two-requester burst arbiter in front of a ping-pong FIFO: grants one
// requester at a time for up to BURST beats, alternating on contention.
// Handshake: a beat transfers on a cycle where ENA and RDY are both high;
// ENA may only be raised while RDY is high.
module pong_arbiter
  import pong_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int BURST = BURST_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in0_req,
  input  logic              in0_enq__ENA,
  input  logic [WIDTH-1:0]  in0_enq_v,
  output logic              in0_enq__RDY,
  input  logic              in1_req,
  input  logic              in1_enq__ENA,
  input  logic [WIDTH-1:0]  in1_enq_v,
  output logic              in1_enq__RDY,
  output logic              out_enq__ENA,
  output logic [WIDTH-1:0]  out_enq_v,
  input  logic              out_enq__RDY,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
  output logic [1:0]        grant,
  input  logic [1:0]        cnt_load_i,
  input  logic [CNT_W-1:0]  cnt_load_val_i,
  output logic [1:0]        dbg_state_o,
  output logic [BEAT_W-1:0] dbg_beats_o,
  output logic              dbg_lastsrv_o
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST - 1);

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beats_q, beats_d;
  logic              lastsrv_q, lastsrv_d;

  logic g0, g1;
  logic rdy0, rdy1;
  logic acc0, acc1;
  logic own_id, own_req, own_acc, other_req;
  logic burst_done, grant_end;

  // Reset masks the handshake combinationally so a grant drops at the reset edge.
  assign g0   = !RST && (state_q == ST_GRANT0);
  assign g1   = !RST && (state_q == ST_GRANT1);
  assign rdy0 = g0 && out_enq__RDY;
  assign rdy1 = g1 && out_enq__RDY;
  assign acc0 = in0_enq__ENA && rdy0;
  assign acc1 = in1_enq__ENA && rdy1;

  assign in0_enq__RDY = rdy0;
  assign in1_enq__RDY = rdy1;
  assign grant        = {g1, g0};
  assign out_enq__ENA = (g0 && in0_enq__ENA) || (g1 && in1_enq__ENA);
  assign out_enq_v    = g1 ? in1_enq_v : (g0 ? in0_enq_v : '0);

  assign own_id     = (state_q == ST_GRANT1);
  assign own_req    = own_id ? in1_req : in0_req;
  assign other_req  = own_id ? in0_req : in1_req;
  assign own_acc    = own_id ? acc1 : acc0;
  assign burst_done = own_acc && (beats_q == LAST_BEAT);
  assign grant_end  = burst_done || (!own_acc && !own_req);

  always_comb begin
    state_d   = state_q;
    beats_d   = beats_q;
    lastsrv_d = lastsrv_q;
    case (state_q)
      ST_IDLE: begin
        beats_d = '0;
        if (in0_req && in1_req) begin
          state_d = lastsrv_q ? ST_GRANT0 : ST_GRANT1;
        end else if (in0_req) begin
          state_d = ST_GRANT0;
        end else if (in1_req) begin
          state_d = ST_GRANT1;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        if (grant_end) begin
          lastsrv_d = own_id;
          beats_d   = '0;
          if (other_req) begin
            state_d = own_id ? ST_GRANT0 : ST_GRANT1;
          end else if (own_req && burst_done) begin
            state_d = state_q;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (own_acc) begin
          beats_d = beats_q + BEAT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        beats_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      beats_q   <= '0;
      lastsrv_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      beats_q   <= beats_d;
      lastsrv_q <= lastsrv_d;
    end
  end

  sat_counter16 u_cnt0 (
    .clk_i      (CLK),
    .rst_i      (RST),
    .inc_i      (acc0),
    .load_i     (cnt_load_i[0]),
    .load_val_i (cnt_load_val_i),
    .count_o    (cnt0)
  );

  sat_counter16 u_cnt1 (
    .clk_i      (CLK),
    .rst_i      (RST),
    .inc_i      (acc1),
    .load_i     (cnt_load_i[1]),
    .load_val_i (cnt_load_val_i),
    .count_o    (cnt1)
  );

  assign dbg_state_o   = state_q;
  assign dbg_beats_o   = beats_q;
  assign dbg_lastsrv_o = lastsrv_q;

endmodule
